// File: rtl/cache_pkg.sv
// Shared types for the set-associative cache controller: FSM state encoding
// and the way-index width helper.
package cache_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        MISS = 1'b1
    } state_e;

    function automatic int way_w_f(input int ways);
        return (ways > 1) ? $clog2(ways) : 1;
    endfunction

endpackage

// File: rtl/cache_ctrl_assoc_if.sv
// Processor request port plus memory/data-array handshake of the cache
// controller. The controller takes the slave side, its environment the master.
interface cache_ctrl_assoc_if #(
    parameter int TAG_W   = 7,
    parameter int INDEX_W = 6,
    parameter int WAYS    = 2
);
    localparam int WAY_W = cache_pkg::way_w_f(WAYS);

    logic               req_valid;
    logic               req_wr;
    logic [TAG_W-1:0]   req_tag;
    logic [INDEX_W-1:0] req_index;
    logic               flush;
    logic               stall;
    logic               cache_hit;
    logic [WAY_W-1:0]   hit_way;
    logic               mem_rd_req;
    logic               mem_wr_en;
    logic               mem_ready;
    logic               update_cache;
    logic [WAY_W-1:0]   update_way;

    modport master (
        output req_valid, req_wr, req_tag, req_index, flush, mem_ready,
        input  stall, cache_hit, hit_way, mem_rd_req, mem_wr_en,
               update_cache, update_way
    );

    modport slave (
        input  req_valid, req_wr, req_tag, req_index, flush, mem_ready,
        output stall, cache_hit, hit_way, mem_rd_req, mem_wr_en,
               update_cache, update_way
    );

endinterface

// File: rtl/cache_lru_age.sv
// True-LRU age update and victim selection for a single set. Age 0 is the
// most recently used way, age WAYS-1 the least recently used.
module cache_lru_age #(
    parameter int WAYS  = 2,
    parameter int WAY_W = 1
) (
    input  logic [WAYS-1:0][WAY_W-1:0] age_i,
    input  logic [WAYS-1:0]            valid_i,
    input  logic [WAY_W-1:0]           touch_i,
    output logic [WAYS-1:0][WAY_W-1:0] age_o,
    output logic [WAY_W-1:0]           victim_o
);

    // NOTE: every output of a combinational block gets a default first, so
    // no path through the block can infer a latch.
    always_comb begin
        age_o = age_i;
        for (int w = 0; w < WAYS; w++) begin
            if (age_i[w] < age_i[touch_i]) begin
                age_o[w] = age_i[w] + 1'b1;
            end
        end
        age_o[touch_i] = '0;
    end

    // Descending scans leave the lowest qualifying way; an invalid way
    // always beats the oldest valid one.
    always_comb begin
        victim_o = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (age_i[w] == WAY_W'(WAYS - 1)) victim_o = WAY_W'(w);
        end
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid_i[w]) victim_o = WAY_W'(w);
        end
    end

endmodule

// File: rtl/cache_ctrl_assoc.sv
// N-way set-associative cache controller: tag/valid/LRU state, IDLE/MISS
// fill state machine, write-through with no write allocation.
module cache_ctrl_assoc
    import cache_pkg::*;
#(
    parameter int TAG_W   = 7,
    parameter int INDEX_W = 6,
    parameter int WAYS    = 2
) (
    input logic               clk,
    input logic               rst_n,
    cache_ctrl_assoc_if.slave bus
);

    localparam int WAY_W = way_w_f(WAYS);
    localparam int SETS  = 1 << INDEX_W;

    typedef logic [WAYS-1:0][WAY_W-1:0] age_vec_t;

    function automatic age_vec_t init_age();
        age_vec_t a;
        for (int w = 0; w < WAYS; w++) a[w] = WAY_W'(w);
        return a;
    endfunction

    state_e             state_q, state_d;
    logic [WAYS-1:0]    valid_q [SETS];
    logic [WAYS-1:0]    valid_d [SETS];
    age_vec_t           age_q   [SETS];
    age_vec_t           age_d   [SETS];
    logic [TAG_W-1:0]   tag_mem [SETS][WAYS];
    logic [TAG_W-1:0]   miss_tag_q, miss_tag_d;
    logic [INDEX_W-1:0] miss_index_q, miss_index_d;
    logic [WAY_W-1:0]   victim_q, victim_d;
    logic               cache_hit_q, cache_hit_d;
    logic [WAY_W-1:0]   hit_way_q, hit_way_d;
    logic               tag_we;

    logic               lookup_hit;
    logic [WAY_W-1:0]   lookup_way;
    logic [INDEX_W-1:0] set_index;
    logic [WAY_W-1:0]   touch_way;
    age_vec_t           touched_age;
    logic [WAY_W-1:0]   lru_victim;

    always_comb begin
        lookup_hit = 1'b0;
        lookup_way = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (valid_q[bus.req_index][w] && (tag_mem[bus.req_index][w] == bus.req_tag)) begin
                lookup_hit = 1'b1;
                lookup_way = WAY_W'(w);
            end
        end
    end

    // One LRU engine serves both the lookup set and the pending fill set.
    assign set_index = (state_q == MISS) ? miss_index_q : bus.req_index;
    assign touch_way = (state_q == MISS) ? victim_q : lookup_way;

    cache_lru_age #(
        .WAYS  (WAYS),
        .WAY_W (WAY_W)
    ) u_lru (
        .age_i    (age_q[set_index]),
        .valid_i  (valid_q[set_index]),
        .touch_i  (touch_way),
        .age_o    (touched_age),
        .victim_o (lru_victim)
    );

    always_comb begin
        state_d          = state_q;
        valid_d          = valid_q;
        age_d            = age_q;
        miss_tag_d       = miss_tag_q;
        miss_index_d     = miss_index_q;
        victim_d         = victim_q;
        cache_hit_d      = 1'b0;
        hit_way_d        = '0;
        tag_we           = 1'b0;
        bus.stall        = 1'b0;
        bus.mem_rd_req   = 1'b0;
        bus.mem_wr_en    = 1'b0;
        bus.update_cache = 1'b0;
        bus.update_way   = '0;

        unique case (state_q)
            IDLE: begin
                if (bus.flush) begin
                    bus.stall = bus.req_valid;
                    for (int s = 0; s < SETS; s++) begin
                        valid_d[s] = '0;
                        age_d[s]   = init_age();
                    end
                end else if (bus.req_valid) begin
                    bus.mem_wr_en = bus.req_wr;
                    if (lookup_hit) begin
                        age_d[bus.req_index] = touched_age;
                        cache_hit_d          = 1'b1;
                        hit_way_d            = lookup_way;
                    end else if (!bus.req_wr) begin
                        bus.stall    = 1'b1;
                        miss_tag_d   = bus.req_tag;
                        miss_index_d = bus.req_index;
                        victim_d     = lru_victim;
                        state_d      = MISS;
                    end
                end
            end
            MISS: begin
                bus.stall      = 1'b1;
                bus.mem_rd_req = 1'b1;
                if (bus.flush) begin
                    for (int s = 0; s < SETS; s++) begin
                        valid_d[s] = '0;
                        age_d[s]   = init_age();
                    end
                    state_d = IDLE;
                end else if (bus.mem_ready) begin
                    bus.update_cache                = 1'b1;
                    bus.update_way                  = victim_q;
                    tag_we                          = 1'b1;
                    valid_d[miss_index_q][victim_q] = 1'b1;
                    age_d[miss_index_q]             = touched_age;
                    state_d                         = IDLE;
                end
            end
        endcase
    end

    assign bus.cache_hit = cache_hit_q;
    assign bus.hit_way   = hit_way_q;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            miss_tag_q   <= '0;
            miss_index_q <= '0;
            victim_q     <= '0;
            cache_hit_q  <= 1'b0;
            hit_way_q    <= '0;
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                age_q[s]   <= init_age();
            end
        end else begin
            state_q      <= state_d;
            valid_q      <= valid_d;
            age_q        <= age_d;
            miss_tag_q   <= miss_tag_d;
            miss_index_q <= miss_index_d;
            victim_q     <= victim_d;
            cache_hit_q  <= cache_hit_d;
            hit_way_q    <= hit_way_d;
        end
    end

    // NOTE: tag storage is deliberately not reset; valid bits gate every use,
    // so it can map onto a plain RAM.
    always_ff @(posedge clk) begin
        if (tag_we) tag_mem[miss_index_q][victim_q] <= miss_tag_q;
    end

endmodule

// File: tb/tb_cache_ctrl_assoc.sv
// Self-checking bench: directed scenarios plus randomized accesses compared
// against a recency-list cache model; a 4-way instance checks LRU eviction.
module tb_cache_ctrl_assoc;

    localparam int TAG_W   = 7;
    localparam int INDEX_W = 6;
    localparam int WAYS    = 2;
    localparam int SETS    = 1 << INDEX_W;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    cache_ctrl_assoc_if #(.TAG_W(TAG_W), .INDEX_W(INDEX_W), .WAYS(WAYS)) bus ();
    cache_ctrl_assoc #(.TAG_W(TAG_W), .INDEX_W(INDEX_W), .WAYS(WAYS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    cache_ctrl_assoc_if #(.TAG_W(7), .INDEX_W(2), .WAYS(4)) bus4 ();
    cache_ctrl_assoc #(.TAG_W(7), .INDEX_W(2), .WAYS(4)) dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus4)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: per-way valid/tag and a recency list, MRU first.
    bit               m_valid [SETS][WAYS];
    logic [TAG_W-1:0] m_tag   [SETS][WAYS];
    int               m_rec   [SETS][$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        for (int s = 0; s < SETS; s++) begin
            m_rec[s].delete();
            for (int w = 0; w < WAYS; w++) begin
                m_valid[s][w] = 1'b0;
                m_rec[s].push_back(w);
            end
        end
    endfunction

    function automatic void model_touch(input int s, input int w);
        for (int i = 0; i < m_rec[s].size(); i++) begin
            if (m_rec[s][i] == w) begin
                m_rec[s].delete(i);
                break;
            end
        end
        m_rec[s].push_front(w);
    endfunction

    function automatic int model_lookup(input int s, input logic [TAG_W-1:0] t);
        for (int w = 0; w < WAYS; w++) begin
            if (m_valid[s][w] && m_tag[s][w] == t) return w;
        end
        return -1;
    endfunction

    function automatic int model_victim(input int s);
        for (int w = 0; w < WAYS; w++) begin
            if (!m_valid[s][w]) return w;
        end
        return m_rec[s][m_rec[s].size() - 1];
    endfunction

    task automatic idle_bus();
        bus.req_valid = 1'b0;
        bus.req_wr    = 1'b0;
        bus.flush     = 1'b0;
        bus.mem_ready = 1'b0;
    endtask

    task automatic do_access(input bit wr, input logic [TAG_W-1:0] tag, input int idx, input int lat);
        int way;
        int vic;
        way = model_lookup(idx, tag);
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_wr    = wr;
        bus.req_tag   = tag;
        bus.req_index = INDEX_W'(idx);
        bus.flush     = 1'b0;
        bus.mem_ready = 1'($urandom_range(0, 1));
        #1;
        check("req_stall", 32'(bus.stall), 32'(!wr && way < 0));
        check("req_mem_wr_en", 32'(bus.mem_wr_en), 32'(wr));
        check("req_update_cache", 32'(bus.update_cache), 32'd0);
        if (wr || way >= 0) begin
            if (way >= 0) model_touch(idx, way);
            @(negedge clk);
            idle_bus();
            check("cache_hit", 32'(bus.cache_hit), 32'(way >= 0));
            check("hit_way", 32'(bus.hit_way), (way >= 0) ? way : 0);
        end else begin
            vic = model_victim(idx);
            for (int c = 1; c <= lat; c++) begin
                @(negedge clk);
                bus.mem_ready = (c == lat);
                #1;
                if (c == 1) check("miss_cache_hit", 32'(bus.cache_hit), 32'd0);
                check("miss_stall", 32'(bus.stall), 32'd1);
                check("miss_mem_rd_req", 32'(bus.mem_rd_req), 32'd1);
                check("miss_update_cache", 32'(bus.update_cache), 32'(c == lat));
                if (c == lat) check("miss_update_way", 32'(bus.update_way), vic);
            end
            m_valid[idx][vic] = 1'b1;
            m_tag[idx][vic]   = tag;
            model_touch(idx, vic);
            @(negedge clk);
            bus.mem_ready = 1'b0;
            #1;
            check("replay_stall", 32'(bus.stall), 32'd0);
            check("replay_mem_rd_req", 32'(bus.mem_rd_req), 32'd0);
            @(negedge clk);
            idle_bus();
            check("replay_cache_hit", 32'(bus.cache_hit), 32'd1);
            check("replay_hit_way", 32'(bus.hit_way), vic);
        end
    endtask

    task automatic flush_idle(input bit wr, input logic [TAG_W-1:0] tag, input int idx);
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_wr    = wr;
        bus.req_tag   = tag;
        bus.req_index = INDEX_W'(idx);
        bus.flush     = 1'b1;
        #1;
        check("flush_stall", 32'(bus.stall), 32'd1);
        check("flush_mem_wr_en", 32'(bus.mem_wr_en), 32'd0);
        model_reset();
        @(negedge clk);
        idle_bus();
        check("flush_cache_hit", 32'(bus.cache_hit), 32'd0);
    endtask

    task automatic flush_miss(input logic [TAG_W-1:0] tag, input int idx);
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_wr    = 1'b0;
        bus.req_tag   = tag;
        bus.req_index = INDEX_W'(idx);
        #1;
        check("fm_req_stall", 32'(bus.stall), 32'd1);
        @(negedge clk);
        #1;
        check("fm_mem_rd_req", 32'(bus.mem_rd_req), 32'd1);
        @(negedge clk);
        bus.flush     = 1'b1;
        bus.mem_ready = 1'b1;
        #1;
        check("fm_update_cache", 32'(bus.update_cache), 32'd0);
        check("fm_stall", 32'(bus.stall), 32'd1);
        model_reset();
        @(negedge clk);
        idle_bus();
        #1;
        check("fm_rd_req_drop", 32'(bus.mem_rd_req), 32'd0);
        check("fm_idle_stall", 32'(bus.stall), 32'd0);
    endtask

    task automatic reset_mid_miss(input logic [TAG_W-1:0] tag, input int idx);
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_wr    = 1'b0;
        bus.req_tag   = tag;
        bus.req_index = INDEX_W'(idx);
        @(negedge clk);
        #1;
        check("rst_pre_rd_req", 32'(bus.mem_rd_req), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check("rst_rd_req", 32'(bus.mem_rd_req), 32'd0);
        check("rst_update_cache", 32'(bus.update_cache), 32'd0);
        check("rst_cache_hit", 32'(bus.cache_hit), 32'd0);
        @(negedge clk);
        idle_bus();
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic acc4(input logic [6:0] tag, input logic [1:0] idx, input bit exp_hit, input int exp_way);
        @(negedge clk);
        bus4.req_valid = 1'b1;
        bus4.req_wr    = 1'b0;
        bus4.req_tag   = tag;
        bus4.req_index = idx;
        #1;
        check("w4_stall", 32'(bus4.stall), 32'(!exp_hit));
        if (!exp_hit) begin
            @(negedge clk);
            bus4.mem_ready = 1'b1;
            #1;
            check("w4_update_cache", 32'(bus4.update_cache), 32'd1);
            check("w4_update_way", 32'(bus4.update_way), exp_way);
            @(negedge clk);
            bus4.mem_ready = 1'b0;
        end
        @(negedge clk);
        bus4.req_valid = 1'b0;
        check("w4_cache_hit", 32'(bus4.cache_hit), 32'd1);
        check("w4_hit_way", 32'(bus4.hit_way), exp_way);
    endtask

    logic [TAG_W-1:0] pool [5];

    initial begin
        pool = '{7'h12, 7'h34, 7'h56, 7'h7F, 7'h01};
        idle_bus();
        bus.req_tag    = '0;
        bus.req_index  = '0;
        bus4.req_valid = 1'b0;
        bus4.req_wr    = 1'b0;
        bus4.req_tag   = '0;
        bus4.req_index = '0;
        bus4.flush     = 1'b0;
        bus4.mem_ready = 1'b0;
        model_reset();

        repeat (2) @(negedge clk);
        #1;
        check("reset_stall", 32'(bus.stall), 32'd0);
        check("reset_mem_rd_req", 32'(bus.mem_rd_req), 32'd0);
        check("reset_mem_wr_en", 32'(bus.mem_wr_en), 32'd0);
        check("reset_update_cache", 32'(bus.update_cache), 32'd0);
        check("reset_update_way", 32'(bus.update_way), 32'd0);
        check("reset_cache_hit", 32'(bus.cache_hit), 32'd0);
        check("reset_hit_way", 32'(bus.hit_way), 32'd0);
        rst_n = 1'b1;

        // Fill, hit, write-through and LRU eviction on set 5.
        do_access(1'b0, 7'h12, 5, 3);
        do_access(1'b0, 7'h34, 5, 2);
        do_access(1'b1, 7'h12, 5, 1);
        do_access(1'b1, 7'h7F, 5, 1);
        do_access(1'b0, 7'h12, 5, 1);
        do_access(1'b0, 7'h56, 5, 2);
        do_access(1'b0, 7'h34, 5, 1);
        do_access(1'b0, 7'h7F, 5, 1);

        // Flush in IDLE and flush colliding with mem_ready in MISS.
        flush_idle(1'b1, 7'h34, 5);
        do_access(1'b0, 7'h12, 5, 1);
        flush_miss(7'h20, 5);
        do_access(1'b0, 7'h12, 5, 2);

        // Asynchronous reset during a fill, then victims follow the reset ages.
        reset_mid_miss(7'h33, 9);
        do_access(1'b0, 7'h12, 5, 1);
        do_access(1'b0, 7'h13, 5, 1);
        do_access(1'b0, 7'h33, 9, 1);

        // 4-way instance: touch ways 0..3 then 0, next miss evicts way 1.
        acc4(7'h10, 2'd1, 1'b0, 0);
        acc4(7'h20, 2'd1, 1'b0, 1);
        acc4(7'h30, 2'd1, 1'b0, 2);
        acc4(7'h40, 2'd1, 1'b0, 3);
        acc4(7'h10, 2'd1, 1'b1, 0);
        acc4(7'h50, 2'd1, 1'b0, 1);

        for (int i = 0; i < 300; i++) begin
            int               r;
            int               idx;
            logic [TAG_W-1:0] t;
            r   = int'($urandom_range(0, 29));
            idx = (($urandom_range(0, 1)) != 0) ? 5 : 6;
            t   = pool[$urandom_range(0, 4)];
            if (r == 0) begin
                flush_idle(1'($urandom_range(0, 1)), t, idx);
            end else if (r == 1 && model_lookup(idx, t) < 0) begin
                flush_miss(t, idx);
            end else begin
                do_access(1'($urandom_range(0, 2) == 0), t, idx, int'($urandom_range(1, 4)));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/cache_ctrl_assoc.md
# cache_ctrl_assoc

Parametrised N-way set-associative cache controller: the tag/valid/replacement engine that sits between the processor request port and the main-memory handshake, driving the separate data array through `update_cache`/`update_way`. It generalises the direct-mapped controller in four ways: configurable associativity, true-LRU replacement, an explicit miss state machine with a memory request/ready handshake, and defined flush-versus-miss arbitration. Writes are write-through, no-write-allocate.

## Interface
- `TAG_W`, 7, tag field width
- `INDEX_W`, 6, set index width (2^INDEX_W sets)
- `WAYS`, 2, associativity; power of two, ≥2; `WAY_W = $clog2(WAYS)`
- `clk`  in  1  clock, rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `req_valid`  in  1  processor request present
- `req_wr`  in  1  1 = write, 0 = read
- `req_tag`  in  TAG_W  request tag
- `req_index`  in  INDEX_W  request set
- `flush`  in  1  invalidate every line
- `stall`  out  1  hold processor; request must stay stable while high
- `cache_hit`  out  1  registered hit flag for the previous cycle's serviced request
- `hit_way`  out  WAY_W  registered way of that hit
- `mem_rd_req`  out  1  block fetch request to memory
- `mem_wr_en`  out  1  write-through strobe to memory
- `mem_ready`  in  1  fetched block available this cycle
- `update_cache`  out  1  data array writes fetched block this cycle
- `update_way`  out  WAY_W  target way for `update_cache`

## Operation
- Storage per set: WAYS × {valid, tag}, WAYS × WAY_W age counters. Tags are not reset.
- Lookup (combinational, IDLE only): hit = some way valid with matching tag; lowest matching way wins (duplicates cannot arise).
- States: IDLE, MISS.
- IDLE, flush=1: all valid bits cleared, all ages reset to way index; `stall`=1 if `req_valid`; `mem_wr_en`=0; request not serviced (replayed next cycle). Stay IDLE.
- IDLE, read hit: `stall`=0; LRU touch of hit way; next cycle `cache_hit`=1, `hit_way`=way.
- IDLE, read miss: `stall`=1; latch tag, index, victim; → MISS.
- IDLE, write: `mem_wr_en`=1, `stall`=0; on hit, LRU touch and `cache_hit`=1 next cycle; on miss, no allocation, `cache_hit`=0 next cycle.
- MISS: `stall`=1, `mem_rd_req`=1. On `mem_ready`=1: `update_cache`=1, `update_way`=latched victim; at that edge write latched tag, set valid, LRU touch victim; → IDLE.
- MISS, flush=1: flush takes priority; valids and ages cleared; miss aborted (no fill even if `mem_ready`=1 same cycle); `mem_rd_req` drops next cycle; → IDLE.
- `mem_ready` in IDLE is ignored.
- Victim: lowest-index invalid way, else the way whose age = WAYS-1.
- LRU touch of way w: every way with age < age[w] increments; age[w] ← 0. Ages remain a permutation of 0..WAYS-1.
- Reset: state IDLE, all valid 0, age[i]=i, all outputs 0.

## Timing
- Read hit: zero stall cycles; `cache_hit` one cycle after request.
- Read miss: stall from request cycle through the `mem_ready` cycle, plus one replay cycle in IDLE that then hits; penalty = memory latency + 1.
- `stall`, `mem_wr_en`, `mem_rd_req`, `update_cache`, `update_way` combinational from state/inputs; `cache_hit`, `hit_way` registered.
- `rst_n` low mid-MISS: immediate return to IDLE, `mem_rd_req`=0 asynchronously, fill lost.

## Structure
- Package `cache_pkg`: state enum (IDLE, MISS), WAY_W computation helper.
- Sub-module `cache_lru_age`: one set's age vector in, touched way in, updated age vector and victim out (combinational); instantiated once on the addressed set.

## Test plan
- Reset, read tag 0x12 index 5 with `mem_ready` after 3 cycles → stall 4 cycles, `update_way`=0, replay hits, `cache_hit`=1, `hit_way`=0.
- Fill tags 0x12, 0x34 into index 5, read 0x12, then miss 0x56 → victim way 1 (0x34 is LRU), later read 0x34 misses.
- Write to index 5 tag 0x12 (hit) and tag 0x7F (miss) → `mem_wr_en`=1 both, `stall`=0, `cache_hit` 1 then 0, no fill for 0x7F.
- Flush asserted in MISS on the same cycle as `mem_ready` → no `update_cache`, state IDLE, subsequent read of any previously cached tag misses.
- `rst_n` pulsed low mid-MISS → `mem_rd_req` falls immediately, all lines invalid, ages 0,1 per set.
- WAYS=4 build: access ways 0,1,2,3 then way 0 on one set → next miss evicts way 1.
